cla_adder_pipe: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups, with valid/ready flow control on both sides. Operand width and pipeline depth are set by parameters. Results also carry signed-overflow and zero flags. It sits in arithmetic datapaths that need wide adds at high clock rates and must tolerate downstream backpressure.

---
 rtl/cla_pkg.sv | 32 +++
 rtl/cla_group4.sv | 40 ++++
 rtl/cla_adder_pipe.sv | 172 +++++++++++++++++
 tb/tb_cla_adder_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// cla_pkg: shared constants, types and helpers for the pipelined
// carry-lookahead adder/subtractor (cla_adder_pipe) and its 4-bit group.
package cla_pkg;

  // Bit width of one lookahead group.
  localparam int CLA_GRP = 4;

  // Context travelling with each operation from stage to stage.
  typedef struct packed {
    logic valid;  // stage register holds a live operation
    logic carry;  // carry into the slice computed by the next stage
    logic sub;    // subtract mode, the next stage inverts its b slice
  } stage_ctx_t;

  // Pipeline depth: one stage per gps lookahead groups. Clamped to 1 so a
  // bad parameter set still elaborates far enough to hit the fatal check.
  function automatic int cla_nstage(input int width, input int gps);
    int n;
    if (gps < 1) begin
      n = 1;
    end else begin
      n = width / (CLA_GRP * gps);
    end
    if (n < 1) begin
      n = 1;
    end else begin
      n = n;
    end
    return n;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// cla_group4: purely combinational 4-bit carry-lookahead group.
// Ports:
//   a, b   in  4  operand bits of this group (b already inverted for subtract)
//   c      in  1  carry into bit 0 of the group
//   sum    out 4  group sum
//   grp_p  out 1  group propagate  P = p3 p2 p1 p0
//   grp_g  out 1  group generate   G = g3 | p3 g2 | p3 p2 g1 | p3 p2 p1 g0
//   c3     out 1  carry into bit 3 (carry into the MSB when this is the top group)
module cla_group4
  import cla_pkg::*;
(
  input  logic [CLA_GRP-1:0] a,
  input  logic [CLA_GRP-1:0] b,
  input  logic               c,
  output logic [CLA_GRP-1:0] sum,
  output logic               grp_p,
  output logic               grp_g,
  output logic               c3
);

  logic [CLA_GRP-1:0] g_s;
  logic [CLA_GRP-1:0] p_s;
  logic               c1_s;
  logic               c2_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // Every internal carry is a flat sum-of-products of c, not a ripple.
  assign c1_s = g_s[0] | (p_s[0] & c);
  assign c2_s = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c);
  assign c3   = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
              | (p_s[2] & p_s[1] & p_s[0] & c);

  assign sum   = p_s ^ {c3, c2_s, c1_s, c};
  assign grp_p = &p_s;
  assign grp_g = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);

endmodule

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: pipelined carry-lookahead adder/subtractor with
// valid/ready flow control, signed-overflow and zero flags.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready = !stall, combinational)
//   a, b [WIDTH]         operands
//   cin                  carry-in (add) / borrow-in (subtract)
//   sub                  0 = a + b + cin, 1 = a - b - cin
//   out_valid / out_ready result handshake
//   sum [WIDTH], cout, ovf, zero   registered result fields
// An operand set accepted at edge t appears after edge t+NSTAGE: one input
// capture register followed by NSTAGE slice stages, the last of which is the
// output register. A single global stall freezes every register.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GPS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSTAGE = cla_nstage(WIDTH, GPS);
  localparam int SW     = CLA_GRP * GPS;  // result bits per stage

  if ((GPS < 1) ? 1'b1 : ((WIDTH % (CLA_GRP * GPS)) != 0)) begin : g_param_check
    $fatal(1, "cla_adder_pipe: GPS must be >= 1 and WIDTH a multiple of 4*GPS");
  end

  logic             stall_s;
  logic             advance_s;
  stage_ctx_t       ctx_in_r;
  logic [WIDTH-1:0] a_in_r;
  logic [WIDTH-1:0] b_in_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;

  assign stall_s   = out_valid_r & ~out_ready;
  assign advance_s = ~stall_s;
  assign in_ready  = advance_s;

  // Input capture: operands, sub mode and effective carry-in c0 = cin ^ sub.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctx_in_r <= '0;
      a_in_r   <= '0;
      b_in_r   <= '0;
    end else if (advance_s) begin
      ctx_in_r.valid <= in_valid;
      ctx_in_r.carry <= cin ^ sub;
      ctx_in_r.sub   <= sub;
      a_in_r         <= a;
      b_in_r         <= b;
    end
  end

  // Stage k computes result bits [SW*k +: SW]. Operand bits above that slice
  // ride along (skew) and the finished lower slices accumulate (deskew), so the
  // registers shrink on the operand side and grow on the result side.
  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int LO  = SW * k;        // first result bit of this stage
    localparam int REM = WIDTH - LO;    // operand bits still pending here

    stage_ctx_t        ctx_cur_s;
    logic [REM-1:0]    a_cur_s;
    logic [REM-1:0]    b_cur_s;
    logic [SW-1:0]     b_eff_s;
    logic [SW-1:0]     s_s;
    logic [GPS:0]      gc_s;            // carries between groups of this stage
    logic [GPS-1:0]    gp_s;
    logic [GPS-1:0]    gg_s;
    logic [GPS-1:0]    c3_s;
    logic [LO+SW-1:0]  res_next_s;
    logic              unused_c3_s;

    if (k == 0) begin : g_src
      assign ctx_cur_s  = ctx_in_r;
      assign a_cur_s    = a_in_r;
      assign b_cur_s    = b_in_r;
      assign res_next_s = s_s;
    end else begin : g_src
      assign ctx_cur_s  = g_stage[k-1].g_mid.ctx_r;
      assign a_cur_s    = g_stage[k-1].g_mid.a_r;
      assign b_cur_s    = g_stage[k-1].g_mid.b_r;
      assign res_next_s = {s_s, g_stage[k-1].g_mid.res_r};
    end

    assign b_eff_s = b_cur_s[SW-1:0] ^ {SW{ctx_cur_s.sub}};
    assign gc_s[0] = ctx_cur_s.carry;

    for (genvar j = 0; j < GPS; j++) begin : g_grp
      cla_group4 u_grp (
        .a     (a_cur_s[CLA_GRP*j +: CLA_GRP]),
        .b     (b_eff_s[CLA_GRP*j +: CLA_GRP]),
        .c     (gc_s[j]),
        .sum   (s_s[CLA_GRP*j +: CLA_GRP]),
        .grp_p (gp_s[j]),
        .grp_g (gg_s[j]),
        .c3    (c3_s[j])
      );
      // Group-to-group carry from G/P only.
      assign gc_s[j+1] = gg_s[j] | (gp_s[j] & gc_s[j]);
    end

    // Only the topmost group's c3 (carry into the MSB) is consumed, for ovf.
    assign unused_c3_s = ^c3_s;

    if (k < NSTAGE - 1) begin : g_mid
      stage_ctx_t        ctx_r;
      logic [LO+SW-1:0]  res_r;
      logic [REM-SW-1:0] a_r;
      logic [REM-SW-1:0] b_r;

      // Stage register: context, finished low slices and pending operand bits.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ctx_r <= '0;
          res_r <= '0;
          a_r   <= '0;
          b_r   <= '0;
        end else if (advance_s) begin
          ctx_r.valid <= ctx_cur_s.valid;
          ctx_r.carry <= gc_s[GPS];
          ctx_r.sub   <= ctx_cur_s.sub;
          res_r       <= res_next_s;
          a_r         <= a_cur_s[REM-1:SW];
          b_r         <= b_cur_s[REM-1:SW];
        end
      end
    end else begin : g_last
      // Output register: full sum plus flags from the MSB group.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_r <= 1'b0;
          sum_r       <= '0;
          cout_r      <= 1'b0;
          ovf_r       <= 1'b0;
          zero_r      <= 1'b0;
        end else if (advance_s) begin
          out_valid_r <= ctx_cur_s.valid;
          sum_r       <= res_next_s;
          cout_r      <= gc_s[GPS];
          ovf_r       <= c3_s[GPS-1] ^ gc_s[GPS];
          zero_r      <= ~|res_next_s;
        end
      end
    end
  end

  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb_cla_adder_pipe: scoreboard bench for cla_adder_pipe. Two instances run on
// one clock: a 16-bit GPS=1 instance for the directed cases and a 32-bit GPS=2
// instance for random traffic. Expected results are queued when an operand set
// is accepted, aged on every non-stalled edge, and compared when presented.
module tb_cla_adder_pipe;

  localparam int NS16 = 4;  // 16 / (4*1)
  localparam int NS32 = 4;  // 32 / (4*2)

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          age;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic        iv16, irdy16, ci16, sb16, ov16, ordy16, co16, of16, z16;
  logic [15:0] a16, b16, sum16;
  logic        iv32, irdy32, ci32, sb32, ov32, ordy32, co32, of32, z32;
  logic [31:0] a32, b32, sum32;

  exp_t q16[$];
  exp_t q32[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic acc [2];

  always #5 clk = ~clk;

  cla_adder_pipe #(.WIDTH(16), .GPS(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(irdy16),
    .a(a16), .b(b16), .cin(ci16), .sub(sb16),
    .out_valid(ov16), .out_ready(ordy16), .sum(sum16),
    .cout(co16), .ovf(of16), .zero(z16)
  );

  cla_adder_pipe #(.WIDTH(32), .GPS(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(irdy32),
    .a(a32), .b(b32), .cin(ci32), .sub(sb32),
    .out_valid(ov32), .out_ready(ordy32), .sum(sum32),
    .cout(co32), .ovf(of32), .zero(z32)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: plain integer arithmetic on w bits.
  function automatic exp_t model(input int w, input logic [31:0] x, input logic [31:0] y,
                                 input logic c, input logic s);
    exp_t        e;
    logic [31:0] mask;
    logic [31:0] beff;
    logic [33:0] full;
    mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    beff   = (s ? ~y : y) & mask;
    full   = {2'b00, x & mask} + {2'b00, beff} + {33'd0, c ^ s};
    e.sum  = full[31:0] & mask;
    e.cout = full[w];
    e.ovf  = (x[w-1] == beff[w-1]) && (e.sum[w-1] != x[w-1]);
    e.zero = (e.sum == 32'd0);
    e.age  = 0;
    return e;
  endfunction

  task automatic put(input int d, input logic v, input logic [31:0] x, input logic [31:0] y,
                     input logic c, input logic s, input logic r);
    if (d == 0) begin
      iv16 = v; a16 = x[15:0]; b16 = y[15:0]; ci16 = c; sb16 = s; ordy16 = r;
    end else begin
      iv32 = v; a32 = x; b32 = y; ci32 = c; sb32 = s; ordy32 = r;
    end
  endtask

  // One cycle of scoreboard work for instance d, called between edges after
  // the inputs for the next edge have been driven.
  task automatic observe(input int d);
    exp_t        q[$];
    logic        o_v, o_r, o_c, o_o, o_z, i_v, i_c, i_s, i_or, ev, stall;
    logic [31:0] o_s, i_a, i_b;
    int          w, ns;
    string       t;
    if (d == 0) begin
      q = q16; w = 16; ns = NS16; t = "w16";
      o_v = ov16; o_r = irdy16; o_s = {16'd0, sum16}; o_c = co16; o_o = of16; o_z = z16;
      i_v = iv16; i_a = {16'd0, a16}; i_b = {16'd0, b16}; i_c = ci16; i_s = sb16; i_or = ordy16;
    end else begin
      q = q32; w = 32; ns = NS32; t = "w32";
      o_v = ov32; o_r = irdy32; o_s = sum32; o_c = co32; o_o = of32; o_z = z32;
      i_v = iv32; i_a = a32; i_b = b32; i_c = ci32; i_s = sb32; i_or = ordy32;
    end
    ev = (q.size() > 0) ? (q[0].age == ns) : 1'b0;
    check_val({t, " out_valid"}, {31'd0, o_v}, {31'd0, ev});
    if (ev) begin
      check_val({t, " sum"},  o_s, q[0].sum);
      check_val({t, " cout"}, {31'd0, o_c}, {31'd0, q[0].cout});
      check_val({t, " ovf"},  {31'd0, o_o}, {31'd0, q[0].ovf});
      check_val({t, " zero"}, {31'd0, o_z}, {31'd0, q[0].zero});
    end
    stall = ev && !i_or;
    check_val({t, " in_ready"}, {31'd0, o_r}, {31'd0, !stall});
    if (ev && i_or) void'(q.pop_front());
    if (!stall) begin
      foreach (q[i]) q[i].age = q[i].age + 1;
    end
    acc[d] = i_v && !stall;
    if (acc[d]) q.push_back(model(w, i_a, i_b, i_c, i_s));
    if (d == 0) q16 = q; else q32 = q;
  endtask

  task automatic step();
    #1;
    observe(0);
    observe(1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [15:0] da [4] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0003};
  logic [15:0] db [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0005};
  logic        dc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic        ds [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int sent;
    int cyc;
    rst_n = 1'b0;
    put(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    put(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check_val("rst out_valid", {31'd0, ov16}, 32'd0);
    check_val("rst sum",       {16'd0, sum16}, 32'd0);
    check_val("rst cout",      {31'd0, co16}, 32'd0);
    check_val("rst ovf",       {31'd0, of16}, 32'd0);
    check_val("rst zero",      {31'd0, z16}, 32'd0);
    check_val("rst in_ready",  {31'd0, irdy16}, 32'd1);
    check_val("rst out_valid32", {31'd0, ov32}, 32'd0);
    rst_n = 1'b1;

    // Directed carry / overflow / borrow corners, back to back.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      put(0, 1'b1, {16'd0, da[i]}, {16'd0, db[i]}, dc[i], ds[i], 1'b1);
      step();
    end
    repeat (8) begin
      @(negedge clk);
      put(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      step();
    end
    check_val("directed drained", q16.size(), 32'd0);

    // Eight back-to-back operations with out_ready low for three cycles.
    sent = 0;
    cyc  = 0;
    while (sent < 8 && cyc < 40) begin
      @(negedge clk);
      put(0, 1'b1, 32'h1111 * (sent + 1), 32'h0F0F ^ sent, sent[1], sent[0],
          !(cyc >= 5 && cyc < 8));
      step();
      if (acc[0]) sent++;
      cyc++;
    end
    check_val("stream sent", sent, 32'd8);
    repeat (10) begin
      @(negedge clk);
      put(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      step();
    end
    check_val("stream drained", q16.size(), 32'd0);

    // Reset with three operations in flight: none may ever emerge.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      put(0, 1'b1, 32'h1000 + i, 32'h0202, 1'b0, 1'b0, 1'b1);
      step();
    end
    @(negedge clk);
    rst_n = 1'b0;
    put(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    #1;
    check_val("mid-reset out_valid", {31'd0, ov16}, 32'd0);
    q16.delete();
    q32.delete();
    @(negedge clk);
    check_val("mid-reset held", {31'd0, ov16}, 32'd0);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      put(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      step();
    end
    @(negedge clk);
    put(0, 1'b1, 32'h1234, 32'h4321, 1'b1, 1'b0, 1'b1);
    step();
    repeat (6) begin
      @(negedge clk);
      put(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      step();
    end
    check_val("post-reset drained", q16.size(), 32'd0);

    // Random traffic on the 32-bit, two-groups-per-stage instance.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      put(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      put(1, ($urandom_range(0, 3) != 0), pick(), pick(),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) != 0));
      step();
    end
    repeat (12) begin
      @(negedge clk);
      put(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      step();
    end
    check_val("random drained", q32.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
